// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the unified memory-port arbiter: FSM encoding,
// grant identifiers and the default bus timeout.
package cpu_mem_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IF_BUSY  = 2'd1,
      MEM_BUSY = 2'd2
   } arb_state_e;

   localparam logic GNT_IF  = 1'b0;
   localparam logic GNT_MEM = 1'b1;

   localparam int unsigned DEFAULT_TIMEOUT = 15;

   function automatic int unsigned cnt_width(input int unsigned limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_arb_timeout_cnt.sv
// Counts BUSY cycles without bus_ack; o_term flags the cycle that reaches TIMEOUT.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timeout_cnt
   import cpu_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic clrn,
   input  logic i_busy,
   input  logic i_ack,
   output logic o_term
);

   localparam int unsigned CNT_W = cnt_width(TIMEOUT);

   logic [CNT_W-1:0] r_cnt;
   logic             w_term;

   // The TIMEOUT-th unacknowledged BUSY cycle is the terminal one.
   assign w_term = i_busy & ~i_ack & (r_cnt == CNT_W'(TIMEOUT - 1));
   assign o_term = w_term;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_cnt <= '0;
      end else if (!i_busy || i_ack || w_term) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the MEM stage.
// Optional bus timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic              stall_if,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_valid,
   output logic              stall_mem,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack,
   output logic              bus_err
);

   arb_state_e        r_state;
   arb_state_e        w_state_nxt;
   logic              r_last_grant;
   logic              r_bus_req;
   logic              r_bus_we;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [DATA_W-1:0] r_bus_wdata;

   logic              w_grant_valid;
   logic              w_grant;
   logic              w_busy;
   logic              w_tmo;
   logic              w_done;
   logic [DATA_W-1:0] w_rdata;

   assign w_busy = (r_state == IF_BUSY) || (r_state == MEM_BUSY);

`ifdef MEM_ARB_TIMEOUT_EN
   mem_arb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk    (clk),
      .clrn   (clrn),
      .i_busy (w_busy),
      .i_ack  (bus_ack),
      .o_term (w_tmo)
   );
`else
   assign w_tmo = 1'b0;
`endif

   assign w_done = w_busy & (bus_ack | w_tmo);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_grant_valid = 1'b0;
      w_grant       = GNT_IF;
      case (r_state)
         IDLE: begin
            if (if_req && mem_req) begin
               w_grant_valid = 1'b1;
               w_grant       = (r_last_grant == GNT_MEM) ? GNT_IF : GNT_MEM;
            end else if (mem_req) begin
               w_grant_valid = 1'b1;
               w_grant       = GNT_MEM;
            end else if (if_req) begin
               w_grant_valid = 1'b1;
               w_grant       = GNT_IF;
            end
            if (w_grant_valid) begin
               w_state_nxt = (w_grant == GNT_MEM) ? MEM_BUSY : IF_BUSY;
            end
         end
         IF_BUSY, MEM_BUSY: begin
            if (bus_ack || w_tmo) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state      <= IDLE;
         r_last_grant <= GNT_IF;
         r_bus_req    <= 1'b0;
         r_bus_we     <= 1'b0;
         r_bus_addr   <= '0;
         r_bus_wdata  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant_valid) begin
            r_last_grant <= w_grant;
            r_bus_req    <= 1'b1;
            if (w_grant == GNT_MEM) begin
               r_bus_addr  <= mem_addr;
               r_bus_we    <= mem_we;
               r_bus_wdata <= mem_wdata;
            end else begin
               r_bus_addr <= if_addr;
               r_bus_we   <= 1'b0;
            end
         end else if (w_done) begin
            r_bus_req <= 1'b0;
         end
      end
   end

   // A timed-out access still completes towards its owner, but with zeroed data.
   assign w_rdata   = w_tmo ? '0 : bus_rdata;
   assign if_rdata  = w_rdata;
   assign mem_rdata = w_rdata;
   assign if_valid  = (r_state == IF_BUSY) & (bus_ack | w_tmo);
   assign mem_valid = (r_state == MEM_BUSY) & (bus_ack | w_tmo);
   assign stall_if  = if_req & ~if_valid;
   assign stall_mem = mem_req & ~mem_valid;

   assign bus_req   = r_bus_req;
   assign bus_we    = r_bus_we;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;
   assign bus_err   = w_tmo;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle vector table plus
// directed sequences for contention, reset mid-access and (optionally) timeout.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        clrn;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        stall_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_valid;
   logic        stall_mem;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        bus_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk       (clk),
      .clrn      (clrn),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_valid  (if_valid),
      .stall_if  (stall_if),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_valid (mem_valid),
      .stall_mem (stall_mem),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack),
      .bus_err   (bus_err)
   );

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        mem_req;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic        bus_ack;
      logic [31:0] bus_rdata;
      logic        e_bus_req;
      logic        e_bus_we;
      logic [31:0] e_bus_addr;
      logic [31:0] e_bus_wdata;
      logic        e_if_valid;
      logic        e_mem_valid;
      logic        e_stall_if;
      logic        e_stall_mem;
      logic        chk_rd;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      if_req    = 1'b0;
      if_addr   = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      bus_ack   = 1'b0;
      bus_rdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      clrn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clrn = 1'b1;
   endtask

   // Serves one grant under contention; called at a negedge in IDLE.
   task automatic serve(input logic exp_mem, input logic [31:0] exp_addr, input string tag);
      logic [31:0] rd;
      rd = exp_addr ^ 32'hF0F0_0000;
      #1;
      check({tag, " idle bus_req"}, 32'(bus_req), 32'd0);
      check({tag, " idle stall_if"}, 32'(stall_if), 32'd1);
      check({tag, " idle stall_mem"}, 32'(stall_mem), 32'd1);
      @(negedge clk);
      #1;
      check({tag, " bus_req"}, 32'(bus_req), 32'd1);
      check({tag, " bus_addr"}, bus_addr, exp_addr);
      bus_ack   = 1'b1;
      bus_rdata = rd;
      #1;
      if (exp_mem) begin
         check({tag, " mem_valid"}, 32'(mem_valid), 32'd1);
         check({tag, " mem_rdata"}, mem_rdata, rd);
         check({tag, " if_valid"}, 32'(if_valid), 32'd0);
         check({tag, " stall_if"}, 32'(stall_if), 32'd1);
      end else begin
         check({tag, " if_valid"}, 32'(if_valid), 32'd1);
         check({tag, " if_rdata"}, if_rdata, rd);
         check({tag, " mem_valid"}, 32'(mem_valid), 32'd0);
         check({tag, " stall_mem"}, 32'(stall_mem), 32'd1);
      end
      @(negedge clk);
      bus_ack = 1'b0;
      if (exp_mem) mem_addr = mem_addr + 32'd4;
      else         if_addr  = if_addr + 32'd4;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // if  ia  mq we ma  wd  ack rd | breq bwe baddr bwd  ifv memv sif smem chk rd
      vecs[0]  = '{0, 0, 1, 0, 32'h100, 0, 0, 0,            0, 0, 0,      0,            0, 0, 0, 1, 0, 0};
      vecs[1]  = '{0, 0, 1, 0, 32'h100, 0, 0, 0,            1, 0, 32'h100, 0,           0, 0, 0, 1, 0, 0};
      vecs[2]  = '{0, 0, 1, 0, 32'h100, 0, 0, 0,            1, 0, 32'h100, 0,           0, 0, 0, 1, 0, 0};
      vecs[3]  = '{0, 0, 1, 0, 32'h100, 0, 0, 0,            1, 0, 32'h100, 0,           0, 0, 0, 1, 0, 0};
      vecs[4]  = '{0, 0, 1, 0, 32'h100, 0, 1, 32'hDEADBEEF, 1, 0, 32'h100, 0,           0, 1, 0, 0, 1, 32'hDEADBEEF};
      vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 32'h100, 0,           0, 0, 0, 0, 0, 0};
      vecs[6]  = '{0, 0, 1, 1, 32'h20, 32'h12345678, 0, 0,  0, 0, 32'h100, 0,           0, 0, 0, 1, 0, 0};
      vecs[7]  = '{0, 0, 1, 1, 32'h20, 32'h12345678, 1, 0,  1, 1, 32'h20, 32'h12345678, 0, 1, 0, 0, 0, 0};
      vecs[8]  = '{1, 32'h0, 0, 0, 0, 0, 1, 32'h55,         0, 1, 32'h20, 32'h12345678, 0, 0, 1, 0, 0, 0};
      vecs[9]  = '{1, 32'h0, 0, 0, 0, 0, 1, 32'hA0,         1, 0, 32'h0, 32'h12345678,  1, 0, 0, 0, 1, 32'hA0};
      vecs[10] = '{1, 32'h4, 0, 0, 0, 0, 1, 32'hA4,         0, 0, 32'h0, 32'h12345678,  0, 0, 1, 0, 0, 0};
      vecs[11] = '{1, 32'h4, 0, 0, 0, 0, 1, 32'hA4,         1, 0, 32'h4, 32'h12345678,  1, 0, 0, 0, 1, 32'hA4};
      vecs[12] = '{1, 32'h8, 0, 0, 0, 0, 1, 32'hA8,         0, 0, 32'h4, 32'h12345678,  0, 0, 1, 0, 0, 0};
      vecs[13] = '{1, 32'h8, 0, 0, 0, 0, 1, 32'hA8,         1, 0, 32'h8, 32'h12345678,  1, 0, 0, 0, 1, 32'hA8};
      vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 32'h8, 32'h12345678,  0, 0, 0, 0, 0, 0};

      clrn = 1'b1;
      idle_inputs();
      #2 clrn = 1'b0;
      #1;
      check("reset bus_req", 32'(bus_req), 32'd0);
      check("reset bus_we", 32'(bus_we), 32'd0);
      check("reset bus_addr", bus_addr, 32'd0);
      check("reset bus_wdata", bus_wdata, 32'd0);
      check("reset if_valid", 32'(if_valid), 32'd0);
      check("reset mem_valid", 32'(mem_valid), 32'd0);
      check("reset bus_err", 32'(bus_err), 32'd0);
      @(negedge clk);
      clrn = 1'b1;

      // Single load, store, then a fetch-only stream, one vector per cycle.
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if_req    = vecs[i].if_req;
         if_addr   = vecs[i].if_addr;
         mem_req   = vecs[i].mem_req;
         mem_we    = vecs[i].mem_we;
         mem_addr  = vecs[i].mem_addr;
         mem_wdata = vecs[i].mem_wdata;
         bus_ack   = vecs[i].bus_ack;
         bus_rdata = vecs[i].bus_rdata;
         #1;
         check($sformatf("v%0d bus_req", i), 32'(bus_req), 32'(vecs[i].e_bus_req));
         check($sformatf("v%0d bus_we", i), 32'(bus_we), 32'(vecs[i].e_bus_we));
         check($sformatf("v%0d bus_addr", i), bus_addr, vecs[i].e_bus_addr);
         check($sformatf("v%0d bus_wdata", i), bus_wdata, vecs[i].e_bus_wdata);
         check($sformatf("v%0d if_valid", i), 32'(if_valid), 32'(vecs[i].e_if_valid));
         check($sformatf("v%0d mem_valid", i), 32'(mem_valid), 32'(vecs[i].e_mem_valid));
         check($sformatf("v%0d stall_if", i), 32'(stall_if), 32'(vecs[i].e_stall_if));
         check($sformatf("v%0d stall_mem", i), 32'(stall_mem), 32'(vecs[i].e_stall_mem));
         check($sformatf("v%0d bus_err", i), 32'(bus_err), 32'd0);
         if (vecs[i].chk_rd) begin
            if (vecs[i].e_if_valid) check($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].e_rdata);
            else                    check($sformatf("v%0d mem_rdata", i), mem_rdata, vecs[i].e_rdata);
         end
      end

      // Contention from reset: MEM first, then strict alternation.
      do_reset();
      @(negedge clk);
      if_req   = 1'b1;
      if_addr  = 32'h0;
      mem_req  = 1'b1;
      mem_we   = 1'b0;
      mem_addr = 32'h200;
      serve(1'b1, 32'h200, "arb0 mem");
      serve(1'b0, 32'h0,   "arb1 if");
      serve(1'b1, 32'h204, "arb2 mem");
      serve(1'b0, 32'h4,   "arb3 if");
      if_req  = 1'b0;
      mem_req = 1'b0;

      // Reset while MEM_BUSY drops the access without a valid pulse.
      do_reset();
      @(negedge clk);
      mem_req  = 1'b1;
      mem_addr = 32'h300;
      @(negedge clk);
      #1;
      check("rst_mid bus_req before", 32'(bus_req), 32'd1);
      check("rst_mid bus_addr before", bus_addr, 32'h300);
      clrn = 1'b0;
      #1;
      check("rst_mid bus_req", 32'(bus_req), 32'd0);
      check("rst_mid bus_addr", bus_addr, 32'd0);
      bus_ack = 1'b1;
      #1;
      check("rst_mid mem_valid", 32'(mem_valid), 32'd0);
      mem_req = 1'b0;
      @(negedge clk);
      clrn = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("rst_post%0d mem_valid", k), 32'(mem_valid), 32'd0);
         check($sformatf("rst_post%0d bus_req", k), 32'(bus_req), 32'd0);
      end
      bus_ack = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
      // Load that is never acknowledged times out after 15 BUSY cycles.
      do_reset();
      @(negedge clk);
      mem_req   = 1'b1;
      mem_addr  = 32'h40;
      bus_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      for (int k = 1; k < 15; k++) begin
         #1;
         check($sformatf("tmo c%0d mem_valid", k), 32'(mem_valid), 32'd0);
         check($sformatf("tmo c%0d bus_err", k), 32'(bus_err), 32'd0);
         @(negedge clk);
      end
      #1;
      check("tmo mem_valid", 32'(mem_valid), 32'd1);
      check("tmo mem_rdata", mem_rdata, 32'd0);
      check("tmo bus_err", 32'(bus_err), 32'd1);
      mem_req = 1'b0;
      if_req  = 1'b1;
      if_addr = 32'h80;
      @(negedge clk);
      #1;
      check("tmo after bus_err", 32'(bus_err), 32'd0);
      check("tmo after bus_req", 32'(bus_req), 32'd0);
      @(negedge clk);
      #1;
      check("tmo if grant bus_req", 32'(bus_req), 32'd1);
      check("tmo if grant bus_addr", bus_addr, 32'h80);
      bus_ack = 1'b1;
      #1;
      check("tmo if_valid", 32'(if_valid), 32'd1);
      @(negedge clk);
      idle_inputs();
`endif

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
